// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the cpu_core inst and data SRAM-like master ports
// onto one SRAM-like memory port. Data wins when both request. A tag FIFO
// remembers which master owns each accepted request so in-order responses
// are routed back to the right master.
//
// Handshake: a master raises <m>_sram_req with stable fields and holds them
// until it sees <m>_sram_addr_ok in the same cycle. mem_req/mem_addr_ok follow
// the same rule on the memory side, and a request is accepted exactly in a
// cycle where mem_req && mem_addr_ok. mem_data_ok is a one-cycle, in-order
// response with no back-pressure.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int PTR_W = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [31:0]       inst_sram_addr,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [31:0]       inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [31:0]       inst_sram_rdata,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [31:0]       data_sram_addr,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata,
  output logic              protocol_err,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_INST = 2'd1,
    HOLD_DATA = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              grant_data;
  logic              grant_req;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_tag;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              tag_mem [MAX_OUTSTANDING];

  assign fifo_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  // Grant selection: live priority in IDLE, frozen while a request is held.
  always_comb begin
    grant_data = 1'b0;
    grant_req  = 1'b0;
    case (state)
      IDLE: begin
        grant_data = data_sram_req;
        grant_req  = data_sram_req | inst_sram_req;
      end
      HOLD_INST: grant_req = inst_sram_req;
      HOLD_DATA: begin
        grant_data = 1'b1;
        grant_req  = data_sram_req;
      end
      default: ;
    endcase
  end

  // A full tag FIFO blocks issue so a response slot always exists.
  assign mem_req = grant_req & ~fifo_full;
  assign accept  = mem_req & mem_addr_ok;

  assign inst_sram_addr_ok = accept & ~grant_data;
  assign data_sram_addr_ok = accept & grant_data;

  // Request field mux; everything reads as zero when no request is issued.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      if (grant_data) begin
        mem_wr    = data_sram_wr;
        mem_size  = data_sram_size;
        mem_addr  = data_sram_addr;
        mem_wstrb = data_sram_wstrb;
        mem_wdata = data_sram_wdata;
      end else begin
        mem_wr    = inst_sram_wr;
        mem_size  = inst_sram_size;
        mem_addr  = inst_sram_addr;
        mem_wstrb = inst_sram_wstrb;
        mem_wdata = inst_sram_wdata;
      end
    end
  end

  // Next grant state: hold the issued master until memory accepts it.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (mem_req && !mem_addr_ok)
          state_n = grant_data ? HOLD_DATA : HOLD_INST;
      end
      HOLD_INST,
      HOLD_DATA: begin
        if (accept)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Response routing: the head tag names the owner of the oldest request.
  assign head_tag          = tag_mem[rd_ptr];
  assign pop               = mem_data_ok & ~fifo_empty;
  assign inst_sram_data_ok = pop & ~head_tag;
  assign data_sram_data_ok = pop & head_tag;
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  // Tag storage; only the pointers and count need reset.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= grant_data;
  end

  // Tag FIFO pointers and occupancy; pointers wrap naturally at the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)                         protocol_err <= 1'b0;
    else if (mem_data_ok && fifo_empty) protocol_err <= 1'b1;
  end

  assign dbg_state = state;
  assign dbg_count = count;

endmodule
